bf16_unit: RTL and testbench

BF16_UNIT -- requirements
Module: BF16Unit

---
 rtl/bf16_unit.sv | 203 ++++++++++++++++++++
 tb/tb_bf16_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bf16_unit.sv
// bf16_unit: single-cycle bfloat16 arithmetic unit (add, sub, mul, max, min,
// neg, abs). One request per cycle, result registered one edge later.
// Build option: define BF16_RNE_EN for round-to-nearest-even on add/sub/mul;
// without it those operations truncate toward zero.
// Handshake: io_in_valid qualifies io_opc/io_a/io_b on the sampling edge; there
// is no ready, every valid request is accepted. io_out_valid is high for exactly
// the one cycle in which io_y carries that request's result; otherwise io_y holds.
module bf16_unit (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        io_in_valid,
   input  logic [2:0]  io_opc,
   input  logic [15:0] io_a,
   input  logic [15:0] io_b,
   output logic [15:0] io_y,
   output logic        io_out_valid
);

   localparam logic [2:0] OPC_ADD = 3'b000;
   localparam logic [2:0] OPC_SUB = 3'b001;
   localparam logic [2:0] OPC_MUL = 3'b010;
   localparam logic [2:0] OPC_MAX = 3'b011;
   localparam logic [2:0] OPC_MIN = 3'b100;
   localparam logic [2:0] OPC_NEG = 3'b101;
   localparam logic [2:0] OPC_ABS = 3'b110;

   localparam logic [15:0] QNAN = 16'h7FC0;

   // m is {8-bit significand with hidden one, guard, round, sticky}; e is the
   // unbiased-by-nothing biased exponent, possibly out of range.
   function automatic logic [15:0] round_pack(input logic s,
                                              input logic signed [10:0] e,
                                              input logic [10:0] m);
      logic             inc;
      logic [8:0]       mr;
      logic signed [10:0] er;
`ifdef BF16_RNE_EN
      inc = m[2] & (m[1] | m[0] | m[3]);
`else
      // bits below the lsb are simply dropped
      inc = 1'b0 & (|m[2:0]);
`endif
      mr = {1'b0, m[10:3]} + {8'd0, inc};
      er = e;
      if (mr[8]) begin
         mr = {1'b0, mr[8:1]};
         er = e + 11'sd1;
      end
      if (er <= 11'sd0)
         return {s, 15'h0000};
      else if (er >= 11'sd255)
         return {s, 8'hFF, 7'h00};
      else
         return {s, er[7:0], mr[6:0]};
   endfunction

   // Add a and b; subtraction is handled by the caller flipping b's sign.
   function automatic logic [15:0] f_add(input logic [15:0] a, input logic [15:0] b);
      logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic               a_big, s_big;
      logic [7:0]         e_big, e_sml, d, ms_big, ms_sml;
      logic [18:0]        sh;
      logic [10:0]        big_x, sml_x, diff, norm;
      logic [11:0]        sum;
      logic [3:0]         lz;
      logic signed [10:0] e_res;
      a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
      b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
      a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
      b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
      a_zero = (a[14:7] == 8'h00);
      b_zero = (b[14:7] == 8'h00);
      if (a_nan || b_nan) return QNAN;
      if (a_inf && b_inf) return (a[15] != b[15]) ? QNAN : {a[15], 8'hFF, 7'h00};
      if (a_inf) return {a[15], 8'hFF, 7'h00};
      if (b_inf) return {b[15], 8'hFF, 7'h00};
      if (a_zero && b_zero) return {a[15] & b[15], 15'h0000};
      if (a_zero) return b;
      if (b_zero) return a;

      a_big  = {a[14:7], a[6:0]} >= {b[14:7], b[6:0]};
      e_big  = a_big ? a[14:7] : b[14:7];
      e_sml  = a_big ? b[14:7] : a[14:7];
      s_big  = a_big ? a[15] : b[15];
      ms_big = a_big ? {1'b1, a[6:0]} : {1'b1, b[6:0]};
      ms_sml = a_big ? {1'b1, b[6:0]} : {1'b1, a[6:0]};
      d      = e_big - e_sml;
      // align the smaller operand, folding everything shifted out into sticky
      sh     = {ms_sml, 11'h000} >> d;
      sml_x  = {sh[18:9], (|sh[8:0]) | (d > 8'd18)};
      big_x  = {ms_big, 3'b000};

      if (a[15] == b[15]) begin
         sum = {1'b0, big_x} + {1'b0, sml_x};
         if (sum[11]) begin
            norm  = {sum[11:2], sum[1] | sum[0]};
            e_res = $signed({3'b000, e_big}) + 11'sd1;
         end else begin
            norm  = sum[10:0];
            e_res = $signed({3'b000, e_big});
         end
      end else begin
         diff = big_x - sml_x;
         if (diff == 11'h000) return 16'h0000;
         lz = 4'd0;
         for (int i = 0; i <= 10; i++)
            if (diff[i]) lz = 4'(10 - i);
         norm  = diff << lz;
         e_res = $signed({3'b000, e_big}) - $signed({7'b0000000, lz});
      end
      return round_pack(s_big, e_res, norm);
   endfunction

   // Multiply a and b.
   function automatic logic [15:0] f_mul(input logic [15:0] a, input logic [15:0] b);
      logic               s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic [15:0]        p;
      logic [10:0]        m;
      logic signed [10:0] e;
      s      = a[15] ^ b[15];
      a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
      b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
      a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
      b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
      a_zero = (a[14:7] == 8'h00);
      b_zero = (b[14:7] == 8'h00);
      if (a_nan || b_nan) return QNAN;
      if ((a_inf && b_zero) || (b_inf && a_zero)) return QNAN;
      if (a_inf || b_inf) return {s, 8'hFF, 7'h00};
      if (a_zero || b_zero) return {s, 15'h0000};

      p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
      e = $signed({3'b000, a[14:7]}) + $signed({3'b000, b[14:7]}) - 11'sd127;
      // product lies in [1,4); a carry into bit 15 bumps the exponent
      if (p[15]) begin
         m = {p[15:6], |p[5:0]};
         e = e + 11'sd1;
      end else begin
         m = {p[14:5], |p[4:0]};
      end
      return round_pack(s, e, m);
   endfunction

   // Ordering for min/max: subnormals read as signed zero, -0 below +0.
   function automatic logic [15:0] f_minmax(input logic [15:0] a, input logic [15:0] b,
                                            input logic want_max);
      logic        a_nan, b_nan, a_lt_b;
      logic [15:0] af, bf;
      a_nan = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
      b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
      af    = (a[14:7] == 8'h00) ? {a[15], 15'h0000} : a;
      bf    = (b[14:7] == 8'h00) ? {b[15], 15'h0000} : b;
      if (a_nan && b_nan) return QNAN;
      if (a_nan) return bf;
      if (b_nan) return af;
      if (af[15] != bf[15])
         a_lt_b = af[15];
      else if (af[15])
         a_lt_b = af[14:0] > bf[14:0];
      else
         a_lt_b = af[14:0] < bf[14:0];
      if (want_max)
         return a_lt_b ? bf : af;
      else
         return a_lt_b ? af : bf;
   endfunction

   logic [15:0] y_q, y_d;
   logic        vld_q, vld_d;

   // Next result: compute on a valid request, otherwise hold.
   always_comb begin
      y_d   = y_q;
      vld_d = io_in_valid;
      if (io_in_valid) begin
         case (io_opc)
            OPC_ADD: y_d = f_add(io_a, io_b);
            OPC_SUB: y_d = f_add(io_a, {~io_b[15], io_b[14:0]});
            OPC_MUL: y_d = f_mul(io_a, io_b);
            OPC_MAX: y_d = f_minmax(io_a, io_b, 1'b1);
            OPC_MIN: y_d = f_minmax(io_a, io_b, 1'b0);
            OPC_NEG: y_d = {~io_a[15], io_a[14:0]};
            OPC_ABS: y_d = {1'b0, io_a[14:0]};
            default: y_d = 16'h0000;
         endcase
      end
   end

   // Output register; reset clears result and valid asynchronously.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         y_q   <= 16'h0000;
         vld_q <= 1'b0;
      end else begin
         y_q   <= y_d;
         vld_q <= vld_d;
      end
   end

   assign io_y         = y_q;
   assign io_out_valid = vld_q;

endmodule

// File: tb/tb_bf16_unit.sv
// Directed bench for bf16_unit: a vector table applied back-to-back, plus
// hand-written reset and hold sequences.
module tb_bf16_unit;

`ifdef BF16_RNE_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [2:0]  opc;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] y;
   } vec_t;

   logic        clock;
   logic        reset_n;
   logic        io_in_valid;
   logic [2:0]  io_opc;
   logic [15:0] io_a;
   logic [15:0] io_b;
   logic [15:0] io_y;
   logic        io_out_valid;

   int n_tests;
   int n_fail;
   vec_t vecs[$];

   bf16_unit dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .io_in_valid  (io_in_valid),
      .io_opc       (io_opc),
      .io_a         (io_a),
      .io_b         (io_b),
      .io_y         (io_y),
      .io_out_valid (io_out_valid)
   );

   // clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %04h expected %04h", name, got, exp);
      end
   endtask

   task automatic add_vec(input string name, input logic [2:0] opc,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] y);
      vec_t v;
      v.name = name; v.opc = opc; v.a = a; v.b = b; v.y = y;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic vld, input logic [2:0] opc,
                        input logic [15:0] a, input logic [15:0] b);
      io_in_valid = vld;
      io_opc      = opc;
      io_a        = a;
      io_b        = b;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      add_vec("add_basic",   3'b000, 16'h41CC, 16'h41AC, 16'h423C);
      add_vec("sub_basic",   3'b001, 16'h41CC, 16'h41AC, 16'h4080);
      add_vec("mul_basic",   3'b010, 16'h41CC, 16'h41AC, 16'h4409);
      add_vec("add_round",   3'b000, 16'h3F81, 16'h3B80, RNE ? 16'h3F82 : 16'h3F81);
      add_vec("mul_round",   3'b010, 16'h3FC1, 16'h3FC1, RNE ? 16'h4012 : 16'h4011);
      add_vec("mul_round_n", 3'b010, 16'hBFC1, 16'h3FC1, RNE ? 16'hC012 : 16'hC011);
      add_vec("sub_tie",     3'b001, 16'h3F80, 16'h3B00, RNE ? 16'h3F80 : 16'h3F7F);
      add_vec("sub_exact",   3'b001, 16'h3F80, 16'h3B80, 16'h3F7F);
      add_vec("mul_ovf",     3'b010, 16'h7F7F, 16'h4000, 16'h7F80);
      add_vec("mul_ovf2",    3'b010, 16'h7F00, 16'h7F00, 16'h7F80);
      add_vec("inf_m_inf",   3'b000, 16'h7F80, 16'hFF80, 16'h7FC0);
      add_vec("cancel",      3'b001, 16'h3F80, 16'h3F80, 16'h0000);
      add_vec("cancel2",     3'b000, 16'h4000, 16'hC000, 16'h0000);
      add_vec("sub_norm",    3'b010, 16'h0001, 16'h3F80, 16'h0000);
      add_vec("mul_unf",     3'b010, 16'h0080, 16'h0080, 16'h0000);
      add_vec("mul_unf_neg", 3'b010, 16'h8080, 16'h0080, 16'h8000);
      add_vec("negz_add",    3'b000, 16'h8000, 16'h8000, 16'h8000);
      add_vec("add_carry",   3'b000, 16'h3F80, 16'h3F80, 16'h4000);
      add_vec("add_mixed",   3'b000, 16'h4040, 16'hBF80, 16'h4000);
      add_vec("mul_sign",    3'b010, 16'hC000, 16'h4040, 16'hC0C0);
      add_vec("inf_add",     3'b000, 16'h7F80, 16'hC000, 16'h7F80);
      add_vec("sub_inf",     3'b001, 16'h3F80, 16'h7F80, 16'hFF80);
      add_vec("ninf_mul",    3'b010, 16'hFF80, 16'h4000, 16'hFF80);
      add_vec("zero_x_inf",  3'b010, 16'h7F80, 16'h0000, 16'h7FC0);
      add_vec("nan_add",     3'b000, 16'h7FC1, 16'h3F80, 16'h7FC0);
      add_vec("max",         3'b011, 16'h41CC, 16'hC1AC, 16'h41CC);
      add_vec("min",         3'b100, 16'h41CC, 16'hC1AC, 16'hC1AC);
      add_vec("neg",         3'b101, 16'h41CC, 16'hC1AC, 16'hC1CC);
      add_vec("abs",         3'b110, 16'hC1AC, 16'h41CC, 16'h41AC);
      add_vec("reserved",    3'b111, 16'h41CC, 16'hC1AC, 16'h0000);
      add_vec("max_nan",     3'b011, 16'h7FC1, 16'h3F80, 16'h3F80);
      add_vec("min_2nan",    3'b100, 16'h7FC1, 16'hFFC3, 16'h7FC0);
      add_vec("max_zeros",   3'b011, 16'h8000, 16'h0000, 16'h0000);
      add_vec("min_zeros",   3'b100, 16'h0000, 16'h8000, 16'h8000);
      add_vec("neg_nan",     3'b101, 16'h7FC1, 16'h0000, 16'hFFC1);
      add_vec("abs_ninf",    3'b110, 16'hFF80, 16'h0000, 16'h7F80);

      // reset state
      drive(1'b0, 3'b000, 16'h0000, 16'h0000);
      reset_n = 1'b0;
      #12;
      check("reset_y", io_y, 16'h0000);
      check("reset_vld", {15'h0, io_out_valid}, 16'h0001 & 16'h0000);
      @(negedge clock);
      reset_n = 1'b1;

      // table, driven on consecutive cycles with valid held high
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].opc, vecs[i].a, vecs[i].b);
         @(posedge clock);
         #1;
         check(vecs[i].name, io_y, vecs[i].y);
         check({vecs[i].name, "_vld"}, {15'h0, io_out_valid}, 16'h0001);
         @(negedge clock);
      end

      // hold: three idle cycles keep the last result, valid drops
      drive(1'b0, 3'b000, 16'h1234, 16'h5678);
      for (int k = 0; k < 3; k++) begin
         @(posedge clock);
         #1;
         check("hold_y", io_y, 16'h7F80);
         check("hold_vld", {15'h0, io_out_valid}, 16'h0000);
      end

      // mid-stream reset clears outputs at once and drops the pending request
      @(negedge clock);
      drive(1'b1, 3'b000, 16'h41CC, 16'h41AC);
      @(posedge clock);
      #1;
      check("pre_rst_y", io_y, 16'h423C);
      drive(1'b1, 3'b010, 16'h41CC, 16'h41AC);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_y", io_y, 16'h0000);
      check("async_rst_vld", {15'h0, io_out_valid}, 16'h0000);
      @(posedge clock);
      #1;
      check("in_rst_y", io_y, 16'h0000);
      @(negedge clock);
      reset_n = 1'b1;
      drive(1'b1, 3'b001, 16'h41CC, 16'h41AC);
      @(posedge clock);
      #1;
      check("post_rst_y", io_y, 16'h4080);
      check("post_rst_vld", {15'h0, io_out_valid}, 16'h0001);
      @(negedge clock);
      drive(1'b0, 3'b000, 16'h0000, 16'h0000);
      @(posedge clock);
      #1;
      check("post_rst_idle", {15'h0, io_out_valid}, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
